// File: rtl/bf_pkg.sv
// Shared opcodes, sequencer state encoding and BCD digit helpers for the Brainfuck core.
package bf_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_HALT  = 4'b0000;
  localparam opcode_t OP_INC   = 4'b0010;
  localparam opcode_t OP_DEC   = 4'b0011;
  localparam opcode_t OP_RIGHT = 4'b0100;
  localparam opcode_t OP_LEFT  = 4'b0101;
  localparam opcode_t OP_LOOP  = 4'b0110;
  localparam opcode_t OP_END   = 4'b0111;
  localparam opcode_t OP_OUT   = 4'b1000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_FETCH     = 3'd1;
  localparam state_t ST_ISSUE     = 3'd2;
  localparam state_t ST_SCAN_FWD  = 3'd3;
  localparam state_t ST_SCAN_BACK = 3'd4;
  localparam state_t ST_HALT      = 3'd5;
  localparam state_t ST_ERROR     = 3'd6;

  // Single BCD digit +1 with 9 -> 0 wrap.
  function automatic bcd_digit_t bcd_digit_inc(input bcd_digit_t d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Single BCD digit -1 with 0 -> 9 wrap.
  function automatic bcd_digit_t bcd_digit_dec(input bcd_digit_t d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter; saturates (holds) instead of wrapping and flags the would-wrap case.
module bcd_updown_counter
  import bf_pkg::*;
#(
  parameter int unsigned DIGITS = 3
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                inc,
  input  logic                dec,
  output logic [4*DIGITS-1:0] value,
  output logic                carry_out_c,
  output logic                borrow_out_c
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] inc_val_c;
  logic [W-1:0] dec_val_c;
  logic         carry_c;
  logic         borrow_c;

  // Ripple carry/borrow through the digits; final carry means all-9s, final borrow means zero.
  always_comb begin
    inc_val_c = value;
    dec_val_c = value;
    carry_c   = 1'b1;
    borrow_c  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry_c) begin
        inc_val_c[4*i +: 4] = bcd_digit_inc(value[4*i +: 4]);
        carry_c             = (value[4*i +: 4] == 4'd9);
      end
      if (borrow_c) begin
        dec_val_c[4*i +: 4] = bcd_digit_dec(value[4*i +: 4]);
        borrow_c            = (value[4*i +: 4] == 4'd0);
      end
    end
  end

  assign carry_out_c  = carry_c;
  assign borrow_out_c = borrow_c;

  // Counter register; a wrapping step is suppressed so the value is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && !carry_c) begin
      value <= inc_val_c;
    end else if (dec && !borrow_c) begin
      value <= dec_val_c;
    end
  end

endmodule

// File: rtl/ip_sequencer.sv
// Instruction-pointer sequencer: fetches BCD-addressed opcodes, issues data/IO ops, resolves brackets by depth scan.
module ip_sequencer
  import bf_pkg::*;
#(
  parameter int unsigned IP_DIGITS    = 3,
  parameter int unsigned DEPTH_DIGITS = 2
)
(
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Request,
  output logic [4*IP_DIGITS-1:0] Address,
  input  logic [3:0]             Data,
  input  logic                   ZeroFlag,
  output logic [3:0]             Insn,
  output logic                   InsnValid,
  input  logic                   InsnReady,
  output logic                   Busy,
  output logic                   Halted,
  output logic                   Error
);

  localparam int unsigned DEPTH_W = 4 * DEPTH_DIGITS;

  state_t             state_q;
  state_t             state_d;
  logic [3:0]         insn_d;
  logic               insn_valid_d;
  logic               halted_d;
  logic               error_d;
  logic               busy_d;
  logic               fault_c;

  logic               ip_clr_c;
  logic               ip_inc_c;
  logic               ip_dec_c;
  logic               ip_carry_c;
  logic               ip_borrow_c;

  logic [DEPTH_W-1:0] depth;
  logic               dp_clr_c;
  logic               dp_inc_c;
  logic               dp_dec_c;
  logic               dp_carry_c;
  logic               dp_borrow_c;
  logic               depth_one_c;

  bcd_updown_counter #(.DIGITS(IP_DIGITS)) u_ip_cnt (
    .clk          (Clk),
    .rst_n        (Rst_n),
    .clear        (ip_clr_c),
    .inc          (ip_inc_c),
    .dec          (ip_dec_c),
    .value        (Address),
    .carry_out_c  (ip_carry_c),
    .borrow_out_c (ip_borrow_c)
  );

  bcd_updown_counter #(.DIGITS(DEPTH_DIGITS)) u_depth_cnt (
    .clk          (Clk),
    .rst_n        (Rst_n),
    .clear        (dp_clr_c),
    .inc          (dp_inc_c),
    .dec          (dp_dec_c),
    .value        (depth),
    .carry_out_c  (dp_carry_c),
    .borrow_out_c (dp_borrow_c)
  );

  // A decrement from depth 1 is the matching bracket.
  assign depth_one_c = (depth == DEPTH_W'(1));

  // Next-state, counter control and registered-output next values.
  always_comb begin
    state_d      = state_q;
    insn_d       = Insn;
    insn_valid_d = InsnValid;
    halted_d     = Halted;
    error_d      = Error;
    fault_c      = 1'b0;
    ip_clr_c     = 1'b0;
    ip_inc_c     = 1'b0;
    ip_dec_c     = 1'b0;
    dp_clr_c     = 1'b0;
    dp_inc_c     = 1'b0;
    dp_dec_c     = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        if (Request) begin
          ip_clr_c = 1'b1;
          dp_clr_c = 1'b1;
          halted_d = 1'b0;
          error_d  = 1'b0;
          state_d  = ST_FETCH;
        end
      end

      ST_FETCH: begin
        case (Data)
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          OP_LOOP: begin
            if (ip_carry_c) begin
              fault_c = 1'b1;
            end else begin
              ip_inc_c = 1'b1;
              if (ZeroFlag) begin
                dp_inc_c = 1'b1;
                state_d  = ST_SCAN_FWD;
              end
            end
          end
          OP_END: begin
            if (!ZeroFlag) begin
              if (ip_borrow_c) begin
                fault_c = 1'b1;
              end else begin
                ip_dec_c = 1'b1;
                dp_inc_c = 1'b1;
                state_d  = ST_SCAN_BACK;
              end
            end else if (ip_carry_c) begin
              fault_c = 1'b1;
            end else begin
              ip_inc_c = 1'b1;
            end
          end
          default: begin
            insn_d       = Data;
            insn_valid_d = 1'b1;
            state_d      = ST_ISSUE;
          end
        endcase
      end

      ST_ISSUE: begin
        if (InsnReady) begin
          insn_valid_d = 1'b0;
          if (ip_carry_c) begin
            fault_c = 1'b1;
          end else begin
            ip_inc_c = 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end

      ST_SCAN_FWD: begin
        if (Data == OP_HALT || dp_borrow_c || ip_carry_c ||
            (Data == OP_LOOP && dp_carry_c)) begin
          fault_c = 1'b1;
        end else begin
          ip_inc_c = 1'b1;
          if (Data == OP_LOOP) begin
            dp_inc_c = 1'b1;
          end else if (Data == OP_END) begin
            dp_dec_c = 1'b1;
            if (depth_one_c) state_d = ST_FETCH;
          end
        end
      end

      ST_SCAN_BACK: begin
        if (Data == OP_HALT || dp_borrow_c || (Data == OP_END && dp_carry_c)) begin
          fault_c = 1'b1;
        end else if (Data == OP_LOOP && depth_one_c) begin
          dp_dec_c = 1'b1;
          if (ip_carry_c) begin
            fault_c = 1'b1;
          end else begin
            ip_inc_c = 1'b1;
            state_d  = ST_FETCH;
          end
        end else if (ip_borrow_c) begin
          fault_c = 1'b1;
        end else begin
          ip_dec_c = 1'b1;
          if (Data == OP_END) begin
            dp_inc_c = 1'b1;
          end else if (Data == OP_LOOP) begin
            dp_dec_c = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any fault freezes IP and depth and parks in ERROR.
    if (fault_c) begin
      ip_inc_c = 1'b0;
      ip_dec_c = 1'b0;
      dp_inc_c = 1'b0;
      dp_dec_c = 1'b0;
      error_d  = 1'b1;
      state_d  = ST_ERROR;
    end

    busy_d = (state_d == ST_FETCH) || (state_d == ST_ISSUE) ||
             (state_d == ST_SCAN_FWD) || (state_d == ST_SCAN_BACK);
  end

  // State and registered status/issue outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      Insn      <= 4'd0;
      InsnValid <= 1'b0;
      Busy      <= 1'b0;
      Halted    <= 1'b0;
      Error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      Insn      <= insn_d;
      InsnValid <= insn_valid_d;
      Busy      <= busy_d;
      Halted    <= halted_d;
      Error     <= error_d;
    end
  end

endmodule

// File: tb/tb_ip_sequencer.sv
// Bench for ip_sequencer: ROM + tape execution unit, reference interpreter feeding a scoreboard.
`timescale 1ns/1ps
module tb_ip_sequencer;
  import bf_pkg::*;

  typedef struct {
    logic [11:0] addr;
    logic [3:0]  op;
    int          gap;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Request = 1'b0;
  logic [11:0] Address;
  logic [3:0]  Data;
  logic        ZeroFlag;
  logic [3:0]  Insn;
  logic        InsnValid;
  logic        InsnReady = 1'b1;
  logic        Busy;
  logic        Halted;
  logic        Error;

  logic [3:0]  rom [0:999];
  logic [7:0]  tape [0:255];
  logic [7:0]  ptr;
  logic        tape_clr = 1'b0;
  int          rom_idx;

  exp_t        sb [$];
  int          exp_halt_gap;
  logic [11:0] exp_halt_addr;
  int          total = 0;
  int          bad = 0;

  ip_sequencer #(.IP_DIGITS(3), .DEPTH_DIGITS(2)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Request   (Request),
    .Address   (Address),
    .Data      (Data),
    .ZeroFlag  (ZeroFlag),
    .Insn      (Insn),
    .InsnValid (InsnValid),
    .InsnReady (InsnReady),
    .Busy      (Busy),
    .Halted    (Halted),
    .Error     (Error)
  );

  always #5 Clk = ~Clk;

  function automatic int from_bcd(input logic [11:0] a);
    return int'(a[11:8]) * 100 + int'(a[7:4]) * 10 + int'(a[3:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    return {4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Combinational program ROM.
  always_comb begin
    rom_idx = from_bcd(Address);
    Data    = (rom_idx < 1000) ? rom[rom_idx] : 4'd0;
  end

  // Execution unit: applies each handshaken op to the data tape.
  always @(posedge Clk) begin
    if (tape_clr) begin
      for (int i = 0; i < 256; i++) tape[i] <= 8'd0;
      ptr <= 8'd0;
    end else if (InsnValid && InsnReady) begin
      case (Insn)
        OP_INC:   tape[ptr] <= tape[ptr] + 8'd1;
        OP_DEC:   tape[ptr] <= tape[ptr] - 8'd1;
        OP_RIGHT: ptr <= ptr + 8'd1;
        OP_LEFT:  ptr <= ptr - 8'd1;
        default:  ;
      endcase
    end
  end

  assign ZeroFlag = (tape[ptr] == 8'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tape_clear();
    tape_clr = 1'b1;
    @(negedge Clk);
    tape_clr = 1'b0;
  endtask

  // which: 0 = hello loop program, 1 = same with a skipped loop.
  task automatic load_prog(input int which);
    for (int i = 0; i < 1000; i++) rom[i] = OP_HALT;
    for (int i = 0; i < 10; i++) rom[i] = (which == 0) ? OP_INC : 4'b0001;
    rom[10] = OP_LOOP;
    rom[11] = OP_RIGHT;
    for (int i = 12; i < 20; i++) rom[i] = OP_INC;
    rom[20] = OP_LOOP;
    rom[21] = OP_DEC;
    for (int i = 22; i < 30; i++) rom[i] = 4'b1001;
    rom[30] = OP_END;
    rom[31] = OP_LEFT;
    for (int i = 32; i < 40; i++) rom[i] = 4'b1001;
    rom[40] = OP_DEC;
    rom[41] = OP_END;
    rom[42] = OP_RIGHT;
    for (int i = 43; i < 110; i++) rom[i] = (i % 2 == 1) ? OP_OUT : OP_INC;
    rom[110] = 4'b1111;
    rom[111] = OP_HALT;
  endtask

  // Reference interpreter: expected issue stream with cycle gaps between handshakes.
  task automatic build_expect();
    int         match [1000];
    int         stk [$];
    logic [7:0] mt [256];
    logic [7:0] mp;
    int         ip;
    int         gap;
    int         steps;
    int         j;
    bit         fin;
    exp_t       e;
    for (int i = 0; i < 1000; i++) match[i] = -1;
    for (int i = 0; i < 256; i++) mt[i] = 8'd0;
    for (int i = 0; i < 1000; i++) begin
      if (rom[i] == OP_LOOP) stk.push_back(i);
      else if (rom[i] == OP_END && stk.size() != 0) begin
        j = stk.pop_back();
        match[i] = j;
        match[j] = i;
      end
    end
    sb.delete();
    mp = 8'd0; ip = 0; gap = 0; steps = 0; fin = 1'b0;
    while (!fin && steps < 50000) begin
      steps++;
      gap++;
      case (rom[ip])
        OP_HALT: fin = 1'b1;
        OP_LOOP: begin
          if (mt[mp] == 8'd0) begin gap += match[ip] - ip; ip = match[ip] + 1; end
          else ip++;
        end
        OP_END: begin
          if (mt[mp] != 8'd0) begin gap += ip - match[ip]; ip = match[ip] + 1; end
          else ip++;
        end
        default: begin
          gap++;
          e.addr = to_bcd(ip);
          e.op   = rom[ip];
          e.gap  = gap;
          sb.push_back(e);
          gap = 0;
          case (rom[ip])
            OP_INC:   mt[mp] = mt[mp] + 8'd1;
            OP_DEC:   mt[mp] = mt[mp] - 8'd1;
            OP_RIGHT: mp = mp + 8'd1;
            OP_LEFT:  mp = mp - 8'd1;
            default:  ;
          endcase
          ip++;
        end
      endcase
    end
    exp_halt_gap  = gap;
    exp_halt_addr = to_bcd(ip);
  endtask

  // Start the loaded program and score every handshake until it halts.
  task automatic run_prog(input int budget);
    int   k = 0;
    int   last = 0;
    bit   done = 1'b0;
    exp_t e;
    build_expect();
    @(negedge Clk);
    Request = 1'b1;
    while (!done && k < budget) begin
      @(negedge Clk);
      k++;
      if (k == 1) begin
        Request = 1'b0;
        check("start_addr", 32'(Address), 32'h0);
        check("start_busy", 32'(Busy), 32'd1);
        check("start_halted", 32'(Halted), 32'd0);
        check("start_error", 32'(Error), 32'd0);
      end
      if (InsnValid && InsnReady) begin
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("insn", 32'(Insn), 32'(e.op));
          check("insn_addr", 32'(Address), 32'(e.addr));
          check("insn_gap", 32'(k - last), 32'(e.gap));
          last = k;
        end
      end
      if (Halted || Error) begin
        done = 1'b1;
        check("end_halted", 32'(Halted), 32'd1);
        check("end_error", 32'(Error), 32'd0);
        check("end_busy", 32'(Busy), 32'd0);
        check("halt_addr", 32'(Address), 32'(exp_halt_addr));
        check("halt_gap", 32'(k - last), 32'(exp_halt_gap + 1));
        check("sb_drained", 32'(sb.size()), 32'd0);
      end
    end
    check("run_done", 32'(done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1000; i++) rom[i] = OP_HALT;
    Rst_n    = 1'b0;
    tape_clr = 1'b1;
    repeat (3) @(negedge Clk);
    tape_clr = 1'b0;
    check("rst_addr", 32'(Address), 32'h0);
    check("rst_insn", 32'(Insn), 32'h0);
    check("rst_valid", 32'(InsnValid), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_halted", 32'(Halted), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    check("idle_busy", 32'(Busy), 32'd0);

    // Loop program: taken brackets, back scans, nested loop, BCD carries.
    load_prog(0);
    tape_clear();
    run_prog(20000);

    // Same program with zero cell at the outer '[': forward scan over nested loop.
    load_prog(1);
    tape_clear();
    run_prog(2000);

    // Execution unit stall: issue held, IP frozen.
    for (int i = 0; i < 1000; i++) rom[i] = OP_HALT;
    rom[0] = OP_INC;
    tape_clear();
    InsnReady = 1'b0;
    Request = 1'b1;
    @(negedge Clk);
    Request = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("stall_valid", 32'(InsnValid), 32'd1);
      check("stall_insn", 32'(Insn), 32'(OP_INC));
      check("stall_addr", 32'(Address), 32'h0);
      check("stall_busy", 32'(Busy), 32'd1);
    end
    InsnReady = 1'b1;
    @(negedge Clk);
    check("post_stall_valid", 32'(InsnValid), 32'd0);
    check("post_stall_addr", 32'(Address), 32'h001);
    @(negedge Clk);
    check("post_stall_halted", 32'(Halted), 32'd1);

    // Unmatched '[' runs into halt opcode during the forward scan.
    rom[0] = OP_LOOP;
    tape_clear();
    Request = 1'b1;
    @(negedge Clk);
    Request = 1'b0;
    repeat (2) @(negedge Clk);
    check("unmatched_error", 32'(Error), 32'd1);
    check("unmatched_halted", 32'(Halted), 32'd0);
    check("unmatched_busy", 32'(Busy), 32'd0);
    check("unmatched_addr", 32'(Address), 32'h001);

    // Reset asserted mid forward scan.
    for (int i = 1; i < 9; i++) rom[i] = OP_INC;
    rom[9] = OP_END;
    tape_clear();
    Request = 1'b1;
    @(negedge Clk);
    Request = 1'b0;
    check("err_cleared", 32'(Error), 32'd0);
    repeat (2) @(negedge Clk);
    check("scan_busy", 32'(Busy), 32'd1);
    check("scan_addr", 32'(Address), 32'h002);
    #2 Rst_n = 1'b0;
    #1;
    check("arst_addr", 32'(Address), 32'h0);
    check("arst_insn", 32'(Insn), 32'h0);
    check("arst_valid", 32'(InsnValid), 32'd0);
    check("arst_busy", 32'(Busy), 32'd0);
    check("arst_halted", 32'(Halted), 32'd0);
    check("arst_error", 32'(Error), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    run_prog(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
